// File: rtl/enemy_pool_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_pool_controller_pkg
//  Description : Slot state encoding, spawn record and per-level spawn table.
//  Revision    : 1.0 - initial release
// ============================================================================
package enemy_pool_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        SQUASH = 2'd2,
        DEAD   = 2'd3
    } enemy_state_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
    } spawn_t;

    // Levels not listed here spawn nothing, leaving the pool empty.
    function automatic spawn_t spawn_entry(input logic [2:0] level, input logic [2:0] idx);
        spawn_t s;
        s = '0;
        case ({level, idx})
            {3'd1, 3'd0}: s = '{1'b1, 10'd600, 10'd400};
            {3'd2, 3'd0}: s = '{1'b1, 10'd600, 10'd400};
            {3'd2, 3'd1}: s = '{1'b1, 10'd596, 10'd396};
            {3'd2, 3'd2}: s = '{1'b1, 10'd300, 10'd200};
            {3'd3, 3'd0}: s = '{1'b1, 10'd20,  10'd100};
            {3'd3, 3'd1}: s = '{1'b1, 10'd1,   10'd50};
            {3'd3, 3'd2}: s = '{1'b1, 10'd320, 10'd240};
            {3'd3, 3'd3}: s = '{1'b1, 10'd630, 10'd420};
            default:      s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_pool_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_pool_controller_if
//  Description : Player/draw inputs and sprite/pulse outputs of the enemy pool.
//  Revision    : 1.0 - initial release
// ============================================================================
interface enemy_pool_controller_if #(
    parameter int NUM_ENEMIES = 4
);
    logic                   frame_clk;
    logic [2:0]             level_num;
    logic [9:0]             DrawX, DrawY;
    logic [9:0]             mario_x, mario_y, luigi_x, luigi_y;
    logic [9:0]             mario_Size_Y, luigi_Size_Y;
    logic [1:0]             mario_health, luigi_health;
    logic                   is_enemy;
    logic                   enemy_walk_count;
    logic                   enemy_squashed;
    logic [8:0]             enemy_address;
    logic [9:0]             enemy_x, enemy_y;
    logic                   mario_hit, luigi_hit, mario_stomp, luigi_stomp;
    logic [NUM_ENEMIES-1:0] alive_mask;
    logic [3:0]             enemies_left;

    modport master (
        output frame_clk, level_num, DrawX, DrawY, mario_x, mario_y, luigi_x, luigi_y,
               mario_Size_Y, luigi_Size_Y, mario_health, luigi_health,
        input  is_enemy, enemy_walk_count, enemy_squashed, enemy_address, enemy_x, enemy_y,
               mario_hit, luigi_hit, mario_stomp, luigi_stomp, alive_mask, enemies_left
    );

    modport slave (
        input  frame_clk, level_num, DrawX, DrawY, mario_x, mario_y, luigi_x, luigi_y,
               mario_Size_Y, luigi_Size_Y, mario_health, luigi_health,
        output is_enemy, enemy_walk_count, enemy_squashed, enemy_address, enemy_x, enemy_y,
               mario_hit, luigi_hit, mario_stomp, luigi_stomp, alive_mask, enemies_left
    );
endinterface
`default_nettype wire

// File: rtl/enemy_pool_controller_slot.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_pool_controller_slot
//  Description : One enemy slot: walk, bound bounce, player collision, squash timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_pool_controller_slot
    import enemy_pool_controller_pkg::*;
#(
    parameter int SPRITE_SZ     = 16,
    parameter int SQUASH_FRAMES = 30,
    parameter int STOMP_WIN     = 4,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  logic         i_respawn,
    input  spawn_t       i_spawn,
    input  logic [9:0]   i_mario_x, i_mario_y, i_mario_h,
    input  logic         i_mario_alive,
    input  logic [9:0]   i_luigi_x, i_luigi_y, i_luigi_h,
    input  logic         i_luigi_alive,
    input  logic [9:0]   i_draw_x, i_draw_y,
    output enemy_state_t o_state,
    output logic [9:0]   o_x, o_y,
    output logic         o_walk, o_visible,
    output logic         o_stomp_m, o_stomp_l, o_hit_m, o_hit_l
);
    localparam int          c_SQ_W = $clog2(SQUASH_FRAMES + 1);
    localparam logic [10:0] c_SZ   = 11'(SPRITE_SZ);
    localparam logic [10:0] c_WIN  = 11'(STOMP_WIN);

    enemy_state_t      r_state, w_state_nx;
    logic [9:0]        r_x, w_x_nx, r_y, w_y_nx;
    logic              r_dir, w_dir_nx, r_walk, w_walk_nx;
    logic [2:0]        r_wcnt, w_wcnt_nx;
    logic [c_SQ_W-1:0] r_sq, w_sq_nx;
    logic              r_stomp_m, r_stomp_l, r_hit_m, r_hit_l;
    logic              w_ovl_m, w_ovl_l, w_low_m, w_low_l;
    logic              w_stomp_m, w_stomp_l, w_hit_m, w_hit_l;

    // Unsigned 11-bit sums so boxes near the 10-bit edge never wrap.
    function automatic logic overlap(input logic [9:0] px, py, ph, ex, ey);
        return ({1'b0, px} < {1'b0, ex} + c_SZ) && ({1'b0, ex} < {1'b0, px} + c_SZ) &&
               ({1'b0, py} < {1'b0, ey} + c_SZ) && ({1'b0, ey} < {1'b0, py} + {1'b0, ph});
    endfunction

    assign w_ovl_m   = i_mario_alive && (r_state == WALK) && overlap(i_mario_x, i_mario_y, i_mario_h, r_x, r_y);
    assign w_ovl_l   = i_luigi_alive && (r_state == WALK) && overlap(i_luigi_x, i_luigi_y, i_luigi_h, r_x, r_y);
    assign w_low_m   = ({1'b0, i_mario_y} + {1'b0, i_mario_h}) <= ({1'b0, r_y} + c_WIN);
    assign w_low_l   = ({1'b0, i_luigi_y} + {1'b0, i_luigi_h}) <= ({1'b0, r_y} + c_WIN);
    assign w_stomp_m = w_ovl_m & w_low_m;
    assign w_stomp_l = w_ovl_l & w_low_l;
    assign w_hit_m   = w_ovl_m & ~w_low_m;
    assign w_hit_l   = w_ovl_l & ~w_low_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_dir     <= 1'b0;
            r_walk    <= 1'b0;
            r_wcnt    <= '0;
            r_sq      <= '0;
            r_stomp_m <= 1'b0;
            r_stomp_l <= 1'b0;
            r_hit_m   <= 1'b0;
            r_hit_l   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_x       <= w_x_nx;
            r_y       <= w_y_nx;
            r_dir     <= w_dir_nx;
            r_walk    <= w_walk_nx;
            r_wcnt    <= w_wcnt_nx;
            r_sq      <= w_sq_nx;
            r_stomp_m <= i_tick & ~i_respawn & w_stomp_m;
            r_stomp_l <= i_tick & ~i_respawn & w_stomp_l;
            r_hit_m   <= i_tick & ~i_respawn & w_hit_m;
            r_hit_l   <= i_tick & ~i_respawn & w_hit_l;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_dir_nx   = r_dir;
        w_walk_nx  = r_walk;
        w_wcnt_nx  = r_wcnt;
        w_sq_nx    = r_sq;
        if (i_respawn) begin
            w_state_nx = i_spawn.valid ? WALK : IDLE;
            w_x_nx     = i_spawn.x;
            w_y_nx     = i_spawn.y;
            w_dir_nx   = 1'b0;
            w_walk_nx  = 1'b0;
            w_wcnt_nx  = '0;
            w_sq_nx    = '0;
        end else if (i_tick) begin
            case (r_state)
                WALK: begin
                    if (w_stomp_m | w_stomp_l) begin
                        w_state_nx = SQUASH;
                        w_sq_nx    = '0;
                    end else begin
                        w_wcnt_nx = r_wcnt + 3'd1;
                        if (r_wcnt == 3'd7)
                            w_walk_nx = ~r_walk;
                        if (!r_dir) begin
                            if (r_x <= 10'(X_MIN + 1)) begin
                                w_x_nx   = 10'(X_MIN);
                                w_dir_nx = 1'b1;
                            end else begin
                                w_x_nx = r_x - 10'd1;
                            end
                        end else begin
                            if (r_x >= 10'(X_MAX - 1)) begin
                                w_x_nx   = 10'(X_MAX);
                                w_dir_nx = 1'b0;
                            end else begin
                                w_x_nx = r_x + 10'd1;
                            end
                        end
                    end
                end
                SQUASH: begin
                    if (r_sq == c_SQ_W'(SQUASH_FRAMES - 1))
                        w_state_nx = DEAD;
                    else
                        w_sq_nx = r_sq + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_visible = ((r_state == WALK) || (r_state == SQUASH)) &&
                       ({1'b0, i_draw_x} >= {1'b0, r_x}) && ({1'b0, i_draw_x} < {1'b0, r_x} + c_SZ) &&
                       ({1'b0, i_draw_y} >= {1'b0, r_y}) && ({1'b0, i_draw_y} < {1'b0, r_y} + c_SZ);
    assign o_state   = r_state;
    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_walk    = r_walk;
    assign o_stomp_m = r_stomp_m;
    assign o_stomp_l = r_stomp_l;
    assign o_hit_m   = r_hit_m;
    assign o_hit_l   = r_hit_l;

endmodule
`default_nettype wire

// File: rtl/enemy_pool_controller.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_pool_controller
//  Description : Enemy slot pool with level respawn, pulse priority and draw mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_pool_controller
    import enemy_pool_controller_pkg::*;
#(
    parameter int NUM_ENEMIES   = 4,
    parameter int SPRITE_SZ     = 16,
    parameter int SQUASH_FRAMES = 30,
    parameter int STOMP_WIN     = 4,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639
) (
    input  logic                    Clk,
    input  logic                    Reset,
    enemy_pool_controller_if.slave  bus
);
    logic                   r_frame_q, r_init;
    logic [2:0]             r_level_q;
    logic                   w_tick, w_respawn;
    enemy_state_t           w_state [NUM_ENEMIES];
    logic [9:0]             w_x [NUM_ENEMIES];
    logic [9:0]             w_y [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] w_walk, w_vis, w_alive;
    logic [NUM_ENEMIES-1:0] w_stomp_m, w_stomp_l, w_hit_m, w_hit_l;
    logic                   w_found, w_sel_walk, w_sel_sq;
    logic [9:0]             w_sel_x, w_sel_y;
    logic [3:0]             w_dx, w_dy, w_count;

    // r_init forces a respawn on the first cycle after reset is released.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q <= 1'b0;
            r_level_q <= bus.level_num;
            r_init    <= 1'b1;
        end else begin
            r_frame_q <= bus.frame_clk;
            r_level_q <= bus.level_num;
            r_init    <= 1'b0;
        end
    end

    assign w_tick    = bus.frame_clk & ~r_frame_q;
    assign w_respawn = ~Reset & (r_init | (bus.level_num != r_level_q));

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
        spawn_t w_spawn;
        assign w_spawn    = spawn_entry(bus.level_num, 3'(i));
        assign w_alive[i] = (w_state[i] == WALK);

        enemy_pool_controller_slot #(
            .SPRITE_SZ     (SPRITE_SZ),
            .SQUASH_FRAMES (SQUASH_FRAMES),
            .STOMP_WIN     (STOMP_WIN),
            .X_MIN         (X_MIN),
            .X_MAX         (X_MAX)
        ) u_slot (
            .clk           (Clk),
            .rst           (Reset),
            .i_tick        (w_tick),
            .i_respawn     (w_respawn),
            .i_spawn       (w_spawn),
            .i_mario_x     (bus.mario_x),
            .i_mario_y     (bus.mario_y),
            .i_mario_h     (bus.mario_Size_Y),
            .i_mario_alive (|bus.mario_health),
            .i_luigi_x     (bus.luigi_x),
            .i_luigi_y     (bus.luigi_y),
            .i_luigi_h     (bus.luigi_Size_Y),
            .i_luigi_alive (|bus.luigi_health),
            .i_draw_x      (bus.DrawX),
            .i_draw_y      (bus.DrawY),
            .o_state       (w_state[i]),
            .o_x           (w_x[i]),
            .o_y           (w_y[i]),
            .o_walk        (w_walk[i]),
            .o_visible     (w_vis[i]),
            .o_stomp_m     (w_stomp_m[i]),
            .o_stomp_l     (w_stomp_l[i]),
            .o_hit_m       (w_hit_m[i]),
            .o_hit_l       (w_hit_l[i])
        );
    end

    // Descending scan so the lowest-index visible slot is the last writer.
    always_comb begin
        w_found    = 1'b0;
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_walk = 1'b0;
        w_sel_sq   = 1'b0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (w_vis[i]) begin
                w_found    = 1'b1;
                w_sel_x    = w_x[i];
                w_sel_y    = w_y[i];
                w_sel_walk = w_walk[i];
                w_sel_sq   = (w_state[i] == SQUASH);
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_ENEMIES; i++)
            w_count = w_count + 4'(w_alive[i]);
    end

    assign w_dx                 = bus.DrawX[3:0] - w_sel_x[3:0];
    assign w_dy                 = bus.DrawY[3:0] - w_sel_y[3:0];
    assign bus.is_enemy         = w_found;
    assign bus.enemy_walk_count = w_sel_walk;
    assign bus.enemy_squashed   = w_sel_sq;
    assign bus.enemy_address    = w_found ? {w_sel_walk, w_dy, w_dx} : 9'd0;
    assign bus.enemy_x          = w_sel_x;
    assign bus.enemy_y          = w_sel_y;
    assign bus.mario_stomp      = |w_stomp_m;
    assign bus.luigi_stomp      = |w_stomp_l;
    assign bus.mario_hit        = (|w_hit_m) & ~(|w_stomp_m);
    assign bus.luigi_hit        = (|w_hit_l) & ~(|w_stomp_l);
    assign bus.alive_mask       = w_alive;
    assign bus.enemies_left     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_enemy_pool_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_pool_controller
//  Description : Directed self-checking bench for the enemy pool controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_pool_controller;
    logic Clk, Reset;
    int   checks = 0;
    int   errors = 0;

    enemy_pool_controller_if #(.NUM_ENEMIES(4)) bus ();

    enemy_pool_controller #(.NUM_ENEMIES(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic players_off();
        bus.mario_x = 10'd0;  bus.mario_y = 10'd0;  bus.mario_Size_Y = 10'd16; bus.mario_health = 2'd0;
        bus.luigi_x = 10'd0;  bus.luigi_y = 10'd0;  bus.luigi_Size_Y = 10'd16; bus.luigi_health = 2'd0;
    endtask

    task automatic do_reset(input logic [2:0] lvl);
        @(negedge Clk);
        Reset = 1'b1; bus.level_num = lvl; bus.frame_clk = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        #1;
    endtask

    task automatic tick();
        @(negedge Clk); bus.frame_clk = 1'b1;
        @(negedge Clk); bus.frame_clk = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        players_off();
        bus.DrawX = 10'd605; bus.DrawY = 10'd405;
        @(negedge Clk);
        Reset = 1'b1; bus.level_num = 3'd1; bus.frame_clk = 1'b0;
        @(negedge Clk); #1;
        checks++; if (bus.alive_mask !== 4'b0000) begin errors++; $display("FAIL reset_alive: got %b expected 0000", bus.alive_mask); end
        checks++; if (bus.is_enemy !== 1'b0) begin errors++; $display("FAIL reset_is_enemy: got %b expected 0", bus.is_enemy); end
        Reset = 1'b0;
        @(negedge Clk); #1;
        checks++; if (bus.alive_mask !== 4'b0001) begin errors++; $display("FAIL spawn_alive: got %b expected 0001", bus.alive_mask); end
        checks++; if (bus.enemies_left !== 4'd1) begin errors++; $display("FAIL spawn_left: got %0d expected 1", bus.enemies_left); end
        checks++; if (bus.enemy_x !== 10'd600 || bus.enemy_y !== 10'd400) begin errors++; $display("FAIL spawn_pos: got %0d,%0d expected 600,400", bus.enemy_x, bus.enemy_y); end
        checks++; if (bus.enemy_address !== 9'h055) begin errors++; $display("FAIL spawn_addr: got %h expected 055", bus.enemy_address); end
    endtask

    task automatic test_walk();
        bus.DrawX = 10'd595; bus.DrawY = 10'd405;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (bus.enemy_x !== 10'd593 || bus.enemy_walk_count !== 1'b0) begin errors++; $display("FAIL walk7: got x=%0d w=%b expected x=593 w=0", bus.enemy_x, bus.enemy_walk_count); end
        tick();
        checks++; if (bus.enemy_walk_count !== 1'b1) begin errors++; $display("FAIL walk8_toggle: got %b expected 1", bus.enemy_walk_count); end
        tick(); tick();
        checks++; if (bus.enemy_x !== 10'd590) begin errors++; $display("FAIL walk10_x: got %0d expected 590", bus.enemy_x); end
        checks++; if (bus.enemy_address !== 9'h155) begin errors++; $display("FAIL walk10_addr: got %h expected 155", bus.enemy_address); end
    endtask

    task automatic test_stomp();
        bus.mario_x = 10'd590; bus.mario_y = 10'd385; bus.mario_health = 2'd2;
        tick();
        checks++; if (bus.mario_stomp !== 1'b1 || bus.mario_hit !== 1'b0) begin errors++; $display("FAIL stomp_pulse: got stomp=%b hit=%b expected 1,0", bus.mario_stomp, bus.mario_hit); end
        checks++; if (bus.enemy_squashed !== 1'b1 || bus.enemy_x !== 10'd590) begin errors++; $display("FAIL stomp_squash: got sq=%b x=%0d expected 1,590", bus.enemy_squashed, bus.enemy_x); end
        checks++; if (bus.enemies_left !== 4'd0) begin errors++; $display("FAIL stomp_left: got %0d expected 0", bus.enemies_left); end
        bus.mario_health = 2'd0;
        @(negedge Clk); #1;
        checks++; if (bus.mario_stomp !== 1'b0) begin errors++; $display("FAIL stomp_width: got %b expected 0", bus.mario_stomp); end
        for (int i = 0; i < 29; i++) tick();
        checks++; if (bus.is_enemy !== 1'b1) begin errors++; $display("FAIL squash29_visible: got %b expected 1", bus.is_enemy); end
        tick();
        checks++; if (bus.is_enemy !== 1'b0 || bus.enemy_x !== 10'd0) begin errors++; $display("FAIL squash30_dead: got is=%b x=%0d expected 0,0", bus.is_enemy, bus.enemy_x); end
    endtask

    task automatic test_level_change();
        players_off();
        do_reset(3'd1);
        bus.mario_x = 10'd600; bus.mario_y = 10'd385; bus.mario_health = 2'd2;
        tick();
        bus.mario_health = 2'd0;
        tick(); tick(); tick();
        bus.DrawX = 10'd605; bus.DrawY = 10'd405;
        #1;
        checks++; if (bus.enemy_squashed !== 1'b1) begin errors++; $display("FAIL pre_change_squash: got %b expected 1", bus.enemy_squashed); end
        @(negedge Clk); bus.level_num = 3'd2;
        @(negedge Clk); #1;
        checks++; if (bus.alive_mask !== 4'b0111 || bus.enemies_left !== 4'd3) begin errors++; $display("FAIL lvl2_alive: got %b/%0d expected 0111/3", bus.alive_mask, bus.enemies_left); end
        checks++; if (bus.enemy_squashed !== 1'b0 || bus.enemy_x !== 10'd600 || bus.enemy_address !== 9'h055) begin errors++; $display("FAIL lvl2_prio: got sq=%b x=%0d a=%h expected 0,600,055", bus.enemy_squashed, bus.enemy_x, bus.enemy_address); end
        bus.DrawX = 10'd597; bus.DrawY = 10'd397; #1;
        checks++; if (bus.enemy_x !== 10'd596 || bus.enemy_y !== 10'd396) begin errors++; $display("FAIL lvl2_slot1: got %0d,%0d expected 596,396", bus.enemy_x, bus.enemy_y); end
    endtask

    task automatic test_double_stomp();
        players_off();
        do_reset(3'd2);
        bus.mario_x = 10'd600; bus.mario_y = 10'd385; bus.mario_health = 2'd2;
        bus.luigi_x = 10'd600; bus.luigi_y = 10'd385; bus.luigi_health = 2'd1;
        tick();
        checks++; if (bus.mario_stomp !== 1'b1 || bus.luigi_stomp !== 1'b1) begin errors++; $display("FAIL dbl_stomp: got m=%b l=%b expected 1,1", bus.mario_stomp, bus.luigi_stomp); end
        checks++; if (bus.mario_hit !== 1'b0 || bus.luigi_hit !== 1'b0) begin errors++; $display("FAIL dbl_hit_suppress: got m=%b l=%b expected 0,0", bus.mario_hit, bus.luigi_hit); end
        checks++; if (bus.alive_mask !== 4'b0110) begin errors++; $display("FAIL dbl_alive: got %b expected 0110", bus.alive_mask); end
        players_off();
    endtask

    task automatic test_side_hit();
        players_off();
        do_reset(3'd2);
        bus.luigi_x = 10'd290; bus.luigi_y = 10'd200; bus.luigi_health = 2'd2;
        tick();
        checks++; if (bus.luigi_hit !== 1'b1 || bus.luigi_stomp !== 1'b0 || bus.mario_hit !== 1'b0) begin errors++; $display("FAIL side_hit: got lh=%b ls=%b mh=%b expected 1,0,0", bus.luigi_hit, bus.luigi_stomp, bus.mario_hit); end
        checks++; if (bus.alive_mask !== 4'b0111) begin errors++; $display("FAIL side_alive: got %b expected 0111", bus.alive_mask); end
        @(negedge Clk); #1;
        checks++; if (bus.luigi_hit !== 1'b0) begin errors++; $display("FAIL side_width: got %b expected 0", bus.luigi_hit); end
        bus.luigi_health = 2'd0;
        tick();
        checks++; if (bus.luigi_hit !== 1'b0) begin errors++; $display("FAIL dead_player_hit: got %b expected 0", bus.luigi_hit); end
    endtask

    task automatic test_bound();
        players_off();
        bus.DrawX = 10'd5; bus.DrawY = 10'd55;
        do_reset(3'd3);
        checks++; if (bus.enemy_x !== 10'd1 || bus.enemy_y !== 10'd50) begin errors++; $display("FAIL bound_start: got %0d,%0d expected 1,50", bus.enemy_x, bus.enemy_y); end
        tick();
        checks++; if (bus.enemy_x !== 10'd0) begin errors++; $display("FAIL bound_clamp: got %0d expected 0", bus.enemy_x); end
        tick();
        checks++; if (bus.enemy_x !== 10'd1) begin errors++; $display("FAIL bound_reverse: got %0d expected 1", bus.enemy_x); end
        tick();
        checks++; if (bus.enemy_x !== 10'd2) begin errors++; $display("FAIL bound_right: got %0d expected 2", bus.enemy_x); end
    endtask

    task automatic test_empty_level();
        @(negedge Clk); bus.level_num = 3'd5;
        @(negedge Clk); #1;
        checks++; if (bus.alive_mask !== 4'b0000 || bus.enemies_left !== 4'd0 || bus.is_enemy !== 1'b0) begin errors++; $display("FAIL empty_level: got %b/%0d/%b expected 0000/0/0", bus.alive_mask, bus.enemies_left, bus.is_enemy); end
    endtask

    task automatic test_reset_mid_walk();
        players_off();
        do_reset(3'd2);
        tick(); tick(); tick();
        bus.DrawX = 10'd605; bus.DrawY = 10'd405; #1;
        checks++; if (bus.enemy_x !== 10'd597) begin errors++; $display("FAIL midwalk_x: got %0d expected 597", bus.enemy_x); end
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); #1;
        checks++; if (bus.is_enemy !== 1'b0 || bus.alive_mask !== 4'b0000 || bus.enemy_x !== 10'd0 || bus.enemy_address !== 9'd0) begin errors++; $display("FAIL midwalk_reset: got is=%b m=%b x=%0d a=%h expected 0,0000,0,000", bus.is_enemy, bus.alive_mask, bus.enemy_x, bus.enemy_address); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        bus.frame_clk = 1'b0; bus.level_num = 3'd0;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
        players_off();
        test_reset();
        test_walk();
        test_stomp();
        test_level_change();
        test_double_stomp();
        test_side_hit();
        test_bound();
        test_empty_level();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
